// File: rtl/vx_tcu_imma_core.sv
// Integer matrix-multiply-accumulate tile core: D = C + A*B over int32/int8/uint8/int4 words.
// Define VX_TCU_IMMA_SAT_EN for exact-precision accumulation with saturation to int32.
module vx_tcu_imma_core #(
  parameter int TC_M    = 2,
  parameter int TC_N    = 2,
  parameter int TC_K    = 2,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_fmt,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [TC_M*TC_K*32-1:0]   in_a,
  input  logic [TC_N*TC_K*32-1:0]   in_b,
  input  logic [TC_M*TC_N*32-1:0]   in_c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_W-1:0]          out_tag,
  output logic [TC_M*TC_N*32-1:0]   out_d
);

  localparam int NE = TC_M * TC_N;
  localparam int NS = LATENCY - 1;
`ifdef VX_TCU_IMMA_SAT_EN
  localparam int DW = 80;
`else
  localparam int DW = 32;
`endif

  logic enable;
  assign enable   = ~out_valid | out_ready;
  assign in_ready = enable;

  function automatic logic [DW-1:0] elem(input logic [31:0] w, input logic [1:0] f, input int e);
    logic [DW-1:0] r;
    r = '0;
    case (f)
      2'd0:    if (e == 0) r = DW'($signed(w));
      2'd1:    if (e < 4) r = DW'($signed(w[(e % 4) * 8 +: 8]));
      2'd2:    if (e < 4) r = DW'(w[(e % 4) * 8 +: 8]);
      default: r = DW'($signed(w[e * 4 +: 4]));
    endcase
    return r;
  endfunction

  function automatic logic [31:0] acc_sum(input logic [DW-1:0] base, input logic [DW-1:0] d);
    logic [DW-1:0] t;
    t = base + d;
`ifdef VX_TCU_IMMA_SAT_EN
    if (t[DW-1:31] != {(DW - 31){t[DW-1]}}) return t[DW-1] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
    return t[31:0];
  endfunction

  // Whole reduction is formed ahead of the first register; remaining stages only delay it.
  logic [NE*DW-1:0] dot;
  always_comb begin
    dot = '0;
    for (int i = 0; i < TC_M; i++) begin
      for (int j = 0; j < TC_N; j++) begin
        for (int k = 0; k < TC_K; k++) begin
          for (int e = 0; e < 8; e++) begin
            dot[(i*TC_N+j)*DW +: DW] = dot[(i*TC_N+j)*DW +: DW]
                + elem(in_a[(i*TC_K+k)*32 +: 32], in_fmt, e)
                * elem(in_b[(j*TC_K+k)*32 +: 32], in_fmt, e);
          end
        end
      end
    end
  end

  logic [NS-1:0]    pv_q, pfirst_q, plast_q;
  logic [TAG_W-1:0] ptag_q [NS];
  logic [NE*32-1:0] pc_q   [NS];
  logic [NE*DW-1:0] pdot_q [NS];
  logic [NE*32-1:0] acc_q;
  logic [NE*32-1:0] sum_w;

  always_comb begin
    sum_w = '0;
    for (int n = 0; n < NE; n++) begin
      sum_w[n*32 +: 32] = acc_sum(pfirst_q[NS-1] ? DW'($signed(pc_q[NS-1][n*32 +: 32]))
                                                 : DW'($signed(acc_q[n*32 +: 32])),
                                  pdot_q[NS-1][n*DW +: DW]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q      <= '0;
      pfirst_q  <= '0;
      plast_q   <= '0;
      for (int s = 0; s < NS; s++) begin
        ptag_q[s] <= '0;
        pc_q[s]   <= '0;
        pdot_q[s] <= '0;
      end
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_d     <= '0;
    end else if (enable) begin
      pv_q[0]     <= in_valid;
      pfirst_q[0] <= in_first;
      plast_q[0]  <= in_last;
      ptag_q[0]   <= in_tag;
      pc_q[0]     <= in_c;
      pdot_q[0]   <= dot;
      for (int s = 1; s < NS; s++) begin
        pv_q[s]     <= pv_q[s-1];
        pfirst_q[s] <= pfirst_q[s-1];
        plast_q[s]  <= plast_q[s-1];
        ptag_q[s]   <= ptag_q[s-1];
        pc_q[s]     <= pc_q[s-1];
        pdot_q[s]   <= pdot_q[s-1];
      end
      // A held result is dropped here only because enable implies it was consumed.
      out_valid <= pv_q[NS-1] & plast_q[NS-1];
      if (pv_q[NS-1]) begin
        acc_q <= sum_w;
        if (plast_q[NS-1]) begin
          out_d   <= sum_w;
          out_tag <= ptag_q[NS-1];
        end
      end
    end
  end

endmodule

// File: doc/vx_tcu_imma_core.md
Name: vx_tcu_imma_core

Overview:
Parametrised integer matrix-multiply-accumulate tile core for the tensor unit. It computes D[TC_M][TC_N] = C + A·B over packed int32/int8/uint8/int4 operands. K can span multiple beats, with accumulation held internally between first and last beat. The pipeline stalls globally on result backpressure, and each result carries a tag back to the issuing warp logic.

Parameters:
TC_M, 2, tile rows (A rows, D rows)
TC_N, 2, tile columns (B columns, D columns)
TC_K, 2, 32-bit words per A row / B column per beat
LATENCY, 3, accept-to-result cycles with no stall; legal range >= 2
TAG_W, 8, width of the opaque tag carried with each beat

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_fmt  in  2  element format: 0=int32 (1/word), 1=int8 (4/word), 2=uint8 (4/word), 3=int4 (8/word)
in_first  in  1  seed accumulator from in_c
in_last  in  1  emit result for this beat
in_tag  in  TAG_W  tag returned with result
in_a  in  TC_M*TC_K*32  A rows; row i word k at index i*TC_K+k
in_b  in  TC_N*TC_K*32  B columns; column j word k at index j*TC_K+k
in_c  in  TC_M*TC_N*32  C; element (i,j) at index i*TC_N+j
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_tag  out  TAG_W  tag of the last beat
out_d  out  TC_M*TC_N*32  D, same indexing as in_c

Behaviour:
- Reset: out_valid=0, out_tag=0, out_d=0, all pipeline valid bits=0, accumulators=0.
- in_ready = enable = ~out_valid || out_ready. All pipeline stages advance only when enable=1. There are no bubbles-only stalls.
- Element e of a word occupies bits [e*W +: W], with W = 32/8/8/4 by fmt. int8 and int4 are sign-extended; uint8 is zero-extended.
- dot(i,j) = sum over k,e of a[i][k].e * b[j][k].e, two's-complement modulo 2^32. In int32 mode the product keeps its low 32 bits.
- The product/reduction tree is registered across the first LATENCY-1 stages. fmt, first, last and tag travel with the beat.
- Final stage (accumulate): when a valid beat enters it, sum = (first ? c(i,j) : acc(i,j)) + dot(i,j). acc(i,j) <= sum.
  - If last=1: out_d <= sum, out_tag <= tag, out_valid <= 1.
  - If last=0: out_valid <= 0 (or remains 0 once the prior result is consumed).
  - in_c is sampled with the beat and carried down the pipeline.
- Timing: a last beat accepted at cycle t with no stall gives out_valid=1 in cycle t+LATENCY.
- out_valid and out_d hold stable until out_ready. A new result may load in the same cycle the old one is consumed, so full throughput is one beat per cycle.
- A non-first beat with no preceding first beat accumulates onto the current acc (0 after reset). This is legal.
- first=1 with last=1 is a single-beat op.
- fmt may differ between beats of one accumulation. Each beat uses its own fmt.
- Accumulation wraps modulo 2^32 by default.
- Reset mid-operation drops all in-flight beats and any held result. No output is produced for them.

Optional Feature:
VX_TCU_IMMA_SAT_EN
- Defined: dot and accumulate are computed at exact precision (signed, wide enough for 2*TC_K 64-bit products plus the accumulator). The final sum is clamped to [0x80000000, 0x7FFFFFFF] before being written to both acc and out_d. Latency is unchanged.
- Undefined: modulo-2^32 wrap as above.

Test Plan:
- int8 single beat: all A words 0x01020304, all B words 0x01010101, C=5, first=last=1 → every out_d element = 25 (0x19) at cycle t+3; out_tag matches.
- int4: all A words 0xFFFFFFFF, all B words 0x11111111, C=0, first=last=1 → every element = -16 (0xFFFFFFF0).
- Multi-beat: beat0 int8 (as above, dot=20) with first=1, last=0, C=100; beat1 int8 (dot=20) with first=0, last=1 → exactly one out_valid, elements = 140, tag is beat1's.
- Backpressure: out_ready=0 for 5 cycles during a stream of 4 last beats → in_ready=0 while out_valid=1; out_d/out_tag stable; after release all 4 results appear in order with none lost or duplicated.
- Overflow: int32, A word0=0x7FFFFFFF, word1=0, B word0=1, word1=0, C=1 → out_d=0x80000000 without VX_TCU_IMMA_SAT_EN; 0x7FFFFFFF with it.
- Reset mid-op: assert reset 1 cycle while 2 beats are in flight → no out_valid afterwards. A following beat with first=0, last=1, dot=20 gives 20 (acc cleared).
